seq_mult_4x4: RTL and testbench

Sequential 4x4 unsigned shift-add multiplier that sits directly upstream of the team's 4-bit ripple-carry adder and drives it once per iteration. It accepts a multiplicand and multiplier on a start/ready handshake and runs four add-and-shift iterations through the adder. It then presents an 8-bit product with a one-cycle done pulse. It is the iterative core of the unsigned-multiply unit.

---
 rtl/mult_pkg.sv | 8 +
 rtl/seq_mult_4x4_if.sv | 14 +
 rtl/FA_4bit.sv | 21 ++
 rtl/seq_mult_4x4.sv | 82 ++++++++
 tb/tb_seq_mult_4x4.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and widths for the sequential 4x4 shift-add multiplier.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  localparam int         MULT_W    = 4;
  localparam int         PROD_W    = 8;
  localparam logic [1:0] ITER_LAST = 2'd3;
endpackage

// File: rtl/seq_mult_4x4_if.sv
// Start/ready request and done/product response bundle of the multiplier.
interface seq_mult_4x4_if;
  import mult_pkg::*;

  logic              start;
  logic [MULT_W-1:0] a;
  logic [MULT_W-1:0] b;
  logic              ready;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (output start, a, b, input ready, done, product);
  modport slave  (input start, a, b, output ready, done, product);
endinterface

// File: rtl/FA_4bit.sv
// 4-bit ripple-carry adder; the multiplier drives it once per iteration.
module FA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_out = c[4];
  end
endmodule

// File: rtl/seq_mult_4x4.sv
// Sequential 4x4 unsigned shift-add multiplier: four add-and-shift
// iterations through FA_4bit, then a one-cycle done pulse with the product.
module seq_mult_4x4
  import mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  seq_mult_4x4_if.slave  bus
);
  mult_state_t       state, state_nxt;
  logic [MULT_W-1:0] m;
  logic [MULT_W-1:0] acc;
  logic [MULT_W-1:0] q;
  logic              c;
  logic [1:0]        cnt;
  logic [PROD_W-1:0] product_r;

  logic [MULT_W-1:0] add_b;
  logic [MULT_W-1:0] sum;
  logic              c_out;

  // Partial product: add the multiplicand only when the current multiplier bit is set.
  assign add_b = q[0] ? m : '0;

  FA_4bit u_add (
    .a     (acc),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == ITER_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            m   <= bus.a;
            q   <= bus.b;
            acc <= '0;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        CALC: begin
          // Shift the 9-bit {carry, sum, Q} right; the adder carry lands in A's MSB.
          {c, acc, q} <= {c_out, sum, q} >> 1;
          cnt         <= cnt + 2'd1;
          if (cnt == ITER_LAST) product_r <= {c_out, sum, q[3:1]};
        end
        default: ;
      endcase
    end
  end

  // C is architecturally part of the shift register but always shifts out as zero.
  logic unused_c;
  assign unused_c = c;

  assign bus.ready   = (state == IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;
endmodule

// File: tb/tb_seq_mult_4x4.sv
// Scoreboard bench for seq_mult_4x4: driver pushes expected products,
// a negedge monitor checks ready/done timing and pops on each done.
module tb_seq_mult_4x4;
  logic clk;
  logic rst_n;
  int   cyc;
  int   acc_cyc;
  int   pass_cnt;
  int   chk_cnt;
  logic [7:0] held_exp;
  logic [7:0] exp_q[$];

  seq_mult_4x4_if mif ();

  seq_mult_4x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: ready/done follow the accept cycle; product only moves on done.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_rdy;
      logic exp_done;
      exp_rdy  = !(cyc >= acc_cyc && cyc <= acc_cyc + 4);
      exp_done = (cyc == acc_cyc + 4);
      chk("ready", int'(mif.ready), int'(exp_rdy));
      chk("done", int'(mif.done), int'(exp_done));
      if (mif.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          held_exp = exp_q.pop_front();
          chk("product", int'(mif.product), int'(held_exp));
        end
      end else begin
        chk("product_hold", int'(mif.product), int'(held_exp));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!mif.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mif.ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input bit push);
    wait_ready();
    mif.start = 1'b1;
    mif.a     = a;
    mif.b     = b;
    acc_cyc   = cyc + 1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    pass_cnt  = 0;
    chk_cnt   = 0;
    acc_cyc   = -100;
    held_exp  = 8'h00;
    rst_n     = 1'b0;
    mif.start = 1'b0;
    mif.a     = 4'd0;
    mif.b     = 4'd0;
    #1;
    chk("rst_ready", int'(mif.ready), 1);
    chk("rst_done", int'(mif.done), 0);
    chk("rst_product", int'(mif.product), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(4'd13, 4'd11, 8'h8F, 1'b1);

    // 15*15: A after iterations 1..3 is 7, 11, 13 (carry enters A's MSB).
    issue(4'd15, 4'd15, 8'hE1, 1'b1);
    @(negedge clk); chk("acc_it1", int'(dut.acc), 7);
    @(negedge clk); chk("acc_it2", int'(dut.acc), 11);
    @(negedge clk); chk("acc_it3", int'(dut.acc), 13);

    issue(4'd0, 4'd9, 8'h00, 1'b1);
    issue(4'd9, 4'd0, 8'h00, 1'b1);

    // Start pulse with other operands during CALC must be ignored.
    issue(4'd7, 4'd6, 8'h2A, 1'b1);
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = 4'd13;
    mif.b     = 4'd2;
    @(negedge clk);
    mif.start = 1'b0;

    // Reset asserted in the second CALC cycle abandons the operation.
    issue(4'd13, 4'd11, 8'h8F, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    acc_cyc  = -100;
    held_exp = 8'h00;
    exp_q.delete();
    #1;
    chk("midrst_ready", int'(mif.ready), 1);
    chk("midrst_done", int'(mif.done), 0);
    chk("midrst_product", int'(mif.product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd3, 4'd5, 8'h0F, 1'b1);

    // start held high: one accept every 6 cycles.
    mif.a     = 4'd2;
    mif.b     = 4'd3;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      mif.start = 1'b1;
      acc_cyc   = cyc + 1;
      exp_q.push_back(8'h06);
      @(negedge clk);
    end
    mif.start = 1'b0;

    repeat (8) @(negedge clk);
    chk("pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
